// File: rtl/tc_pu_drain.sv
// rtl/tc_pu_drain.sv - PU accumulator drain: 2-entry vector FIFO, requantize, serialize one element per beat
module tc_pu_drain #(
    parameter int N_UNIT  = 4,
    parameter int DW_ADD  = 32,
    parameter int DW_OUT  = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_UNIT*DW_ADD-1:0] acc_in,
    input  logic                     acc_done,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     relu_en,
    output logic [DW_OUT-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     drop,
    input  logic                     drop_clr
);

    localparam int IW = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_UNIT - 1);
    localparam logic signed [DW_ADD:0] OMAX = (DW_ADD+1)'((1 << (DW_OUT - 1)) - 1);
    localparam logic signed [DW_ADD:0] OMIN = -OMAX - 1;

    typedef enum logic {S_EMPTY, S_DRAIN} state_t;

    state_t                    state, state_nx;
    logic [N_UNIT*DW_ADD-1:0]  head_acc, head_acc_nx, tail_acc, tail_acc_nx;
    logic [SHIFT_W-1:0]        head_sh, head_sh_nx, tail_sh, tail_sh_nx;
    logic                      head_relu, head_relu_nx, tail_relu, tail_relu_nx;
    logic [1:0]                cnt, cnt_nx, cnt_after;
    logic [IW-1:0]             idx, idx_nx;
    logic [DW_OUT-1:0]         data_nx;
    logic                      beat, pop, push, drop_set;

    // Round-half-up, arithmetic shift, optional ReLU, then saturate to DW_OUT.
    function automatic logic [DW_OUT-1:0] requant(input logic [DW_ADD-1:0] x,
                                                  input logic [SHIFT_W-1:0] sh,
                                                  input logic relu);
        logic signed [DW_ADD:0] s;
        logic signed [DW_ADD:0] r;
        s = {x[DW_ADD-1], x};
        if (sh != '0)
            s = s + ((DW_ADD+1)'(1) << (sh - SHIFT_W'(1)));
        r = s >>> sh;
        if (relu && r[DW_ADD])
            r = '0;
        if (r > OMAX)
            r = OMAX;
        else if (r < OMIN)
            r = OMIN;
        return r[DW_OUT-1:0];
    endfunction

    assign busy      = (state == S_DRAIN);
    assign out_valid = busy;
    assign out_last  = busy & (idx == LAST_IDX);

    always_comb begin
        head_acc_nx  = head_acc;
        head_sh_nx   = head_sh;
        head_relu_nx = head_relu;
        tail_acc_nx  = tail_acc;
        tail_sh_nx   = tail_sh;
        tail_relu_nx = tail_relu;
        state_nx     = state;

        beat      = out_valid & out_ready;
        pop       = beat & (idx == LAST_IDX);
        cnt_after = cnt - {1'b0, pop};
        push      = acc_done & (cnt_after != 2'd2);
        drop_set  = acc_done & (cnt_after == 2'd2);

        if (pop) begin
            head_acc_nx  = tail_acc;
            head_sh_nx   = tail_sh;
            head_relu_nx = tail_relu;
        end
        // A push lands in whichever slot is free after this cycle's pop.
        if (push) begin
            if (cnt_after == 2'd0) begin
                head_acc_nx  = acc_in;
                head_sh_nx   = shift;
                head_relu_nx = relu_en;
            end else begin
                tail_acc_nx  = acc_in;
                tail_sh_nx   = shift;
                tail_relu_nx = relu_en;
            end
        end
        cnt_nx = cnt_after + {1'b0, push};

        if (beat)
            idx_nx = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        else
            idx_nx = idx;

        case (state)
            S_EMPTY: if (acc_done) state_nx = S_DRAIN;
            S_DRAIN: if (pop && cnt == 2'd1 && !acc_done) state_nx = S_EMPTY;
            default: state_nx = S_EMPTY;
        endcase

        // out_data is registered with the element that will be presented next cycle.
        if (cnt_nx != 2'd0)
            data_nx = requant(head_acc_nx[DW_ADD*idx_nx +: DW_ADD], head_sh_nx, head_relu_nx);
        else
            data_nx = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_EMPTY;
            head_acc  <= '0;
            head_sh   <= '0;
            head_relu <= 1'b0;
            tail_acc  <= '0;
            tail_sh   <= '0;
            tail_relu <= 1'b0;
            cnt       <= 2'd0;
            idx       <= '0;
            out_data  <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nx;
            head_acc  <= head_acc_nx;
            head_sh   <= head_sh_nx;
            head_relu <= head_relu_nx;
            tail_acc  <= tail_acc_nx;
            tail_sh   <= tail_sh_nx;
            tail_relu <= tail_relu_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            out_data  <= data_nx;
            if (drop_set)
                drop <= 1'b1;
            else if (drop_clr)
                drop <= 1'b0;
        end
    end

endmodule

// File: doc/tc_pu_drain.md
TC_PU_DRAIN -- requirements
Module: tc_pu_drain

Interface
REQ-001 SHALL have parameter N_UNIT, default 4: number of PE accumulators per vector.
REQ-002 SHALL have parameter DW_ADD, default 32: signed accumulator width per element.
REQ-003 SHALL have parameter DW_OUT, default 8: signed output element width.
REQ-004 SHALL have parameter SHIFT_W, default 5: width of the requant shift field.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port acc_in  input  N_UNIT*DW_ADD  signed accumulators from the PU, element i at bits [DW_ADD*i +: DW_ADD].
REQ-008 SHALL have port acc_done  input  1  one-cycle pulse; acc_in is final in this cycle.
REQ-009 SHALL have port shift  input  SHIFT_W  arithmetic right-shift amount, sampled with acc_done.
REQ-010 SHALL have port relu_en  input  1  clamp negatives to 0, sampled with acc_done.
REQ-011 SHALL have port out_data  output  DW_OUT  requantized signed element.
REQ-012 SHALL have port out_valid  output  1  out_data valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-014 SHALL have port out_last  output  1  marks element N_UNIT-1 of a vector.
REQ-015 SHALL have port busy  output  1  high while any vector is buffered.
REQ-016 SHALL have port drop  output  1  sticky; a vector was lost to overflow.
REQ-017 SHALL have port drop_clr  input  1  synchronous clear of drop.

Function
REQ-018 SHALL hold a 2-entry FIFO; each entry stores acc_in, shift and relu_en captured on the acc_done edge.
REQ-019 SHALL serialize the head entry one element per beat, element 0 first, as a two-state machine: EMPTY (FIFO empty) and DRAIN (FIFO non-empty).
REQ-020 SHALL transition EMPTY->DRAIN on acc_done, and DRAIN->EMPTY on acceptance of the last element when the FIFO holds one entry and acc_done is low.
REQ-021 SHALL complete a beat only when out_valid and out_ready are both high; the element index then increments, wrapping to 0 after N_UNIT-1 and popping the head entry.
REQ-022 SHALL hold out_data and out_last stable while out_valid is high and out_ready is low; out_valid SHALL NOT deassert before acceptance.
REQ-023 SHALL drive out_valid = busy and out_last = (index == N_UNIT-1) & out_valid; outputs derive only from registers.
REQ-024 SHALL present element 0 of a vector captured at edge t on out_valid/out_data after edge t when the FIFO was empty (1-cycle latency).
REQ-025 SHALL requantize as: x + (shift>0 ? 2^(shift-1) : 0), computed in DW_ADD+1 bits, then arithmetic shift right by shift, then clamp to 0 if relu_en, then saturate to [-2^(DW_OUT-1), 2^(DW_OUT-1)-1].
REQ-026 SHALL, on acc_done with FIFO full and no pop in the same cycle, discard the vector and set drop.
REQ-027 SHALL, on acc_done coinciding with the last-element pop of a full FIFO, accept the new vector.
REQ-028 SHALL give drop set priority over drop_clr in the same cycle.

Reset
REQ-029 SHALL, while reset is low, force FIFO empty, index 0, state EMPTY, out_valid 0, out_last 0, out_data 0, busy 0, drop 0, regardless of clk.
REQ-030 SHALL abandon any partially drained vector on reset; no beat after reset release refers to it.

Verification
REQ-031 SHALL verify: acc_done with elements {24,-24,7,0}, shift=4, relu_en=0, out_ready=1 -> beats 2,-1,0,0 on consecutive cycles, out_last on the 4th.
REQ-032 SHALL verify: elements {1000,-1000,127,-129}, shift=0 -> 127,-128,127,-128; same vector with relu_en=1 -> 127,0,127,0.
REQ-033 SHALL verify: out_ready low 3 cycles mid-vector -> out_data/out_last unchanged, no element skipped or repeated.
REQ-034 SHALL verify: three acc_done pulses on consecutive cycles with out_ready=0 -> vectors 1 and 2 drained in order, vector 3 lost, drop=1 until drop_clr.
REQ-035 SHALL verify: FIFO full, acc_done on the cycle the last element of the head is accepted -> no drop, new vector drained after the second.
REQ-036 SHALL verify: reset asserted after element 1 of a vector -> all outputs 0 immediately; after release with no acc_done, out_valid stays 0.
